// File: rtl/led_pwm_driver_if.sv
// Configuration write port for led_pwm_driver (cs/write/addr/data from memorio).
// The master drives the bus; the driver itself only listens.
interface led_pwm_driver_if;
  logic        cfgcs;
  logic        cfgwrite;
  logic [1:0]  cfgaddr;
  logic [15:0] cfgwdata;

  modport master (output cfgcs, output cfgwrite, output cfgaddr, output cfgwdata);
  modport slave  (input  cfgcs, input  cfgwrite, input  cfgaddr, input  cfgwdata);
endinterface

// File: rtl/led_pwm_driver.sv
// Board LED driver: global PWM brightness plus per-byte-group blinking on the latched LED word.
// Build option: define LED_GAMMA_EN to apply a square-law gamma curve to the duty setting.
module led_pwm_driver #(
  parameter int PRESCALE = 16,
  parameter int PCNT_W   = 16
) (
  input  logic                 led_clk,
  input  logic                 ledrst,
  led_pwm_driver_if.slave      cfg,
  input  logic [23:0]          ledin,
  output logic [23:0]          ledpin,
  output logic                 blink_phase,
  output logic                 pwm_wrap
);

  localparam logic [PCNT_W-1:0] PRE_LAST = PCNT_W'(PRESCALE - 1);

  logic [7:0]        duty;
  logic [15:0]       period;
  logic [2:0]        mask;
  logic [PCNT_W-1:0] pre_cnt;
  logic [7:0]        pwm_cnt;
  logic [15:0]       blink_cnt;

  logic              cfg_we;
  logic              tick;
  logic              wrap_evt;
  logic              pwm_on_p0;
  logic [23:0]       grp_en_p0;

  // Duty actually compared against pwm_cnt; 8'hFF is handled separately as always-on.
  function automatic logic [7:0] eff_duty(input logic [7:0] d);
`ifdef LED_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(d) * 16'(d);
    return sq[15:8];
`else
    return d;
`endif
  endfunction

  assign cfg_we   = cfg.cfgcs & cfg.cfgwrite;
  assign tick     = (pre_cnt == PRE_LAST);
  assign wrap_evt = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      duty   <= 8'hFF;
      period <= 16'h0000;
      mask   <= 3'b000;
    end else if (cfg_we) begin
      case (cfg.cfgaddr)
        2'b00:   duty   <= cfg.cfgwdata[7:0];
        2'b01:   period <= cfg.cfgwdata;
        2'b10:   mask   <= cfg.cfgwdata[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // A period write restarts the blink sequence even if it lands on a wrap.
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (cfg_we && (cfg.cfgaddr == 2'b01)) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (period == 16'd0) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (wrap_evt) begin
      if (blink_cnt == period - 16'd1) begin
        blink_cnt   <= 16'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // ---- stage p0: gating terms from current PWM/blink state ----
  always_comb begin
    pwm_on_p0 = (duty == 8'hFF) || (pwm_cnt < eff_duty(duty));
    grp_en_p0 = '0;
    for (int g = 0; g < 3; g++)
      grp_en_p0[8*g +: 8] = {8{blink_phase | ~mask[g]}};
  end

  // ---- stage p1: registered pins ----
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      ledpin   <= 24'h000000;
      pwm_wrap <= 1'b0;
    end else begin
      ledpin   <= ledin & {24{pwm_on_p0}} & grp_en_p0;
      pwm_wrap <= wrap_evt;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomized bench for led_pwm_driver: two instances (PRESCALE 1 and 3) against a time-based reference model.
module tb_led_pwm_driver;

  logic        led_clk = 1'b0;
  logic        ledrst;
  logic [23:0] ledin;
  logic [23:0] ledpin0, ledpin1;
  logic        blink0, blink1;
  logic        wrap0, wrap1;

  int n_chk = 0;
  int n_err = 0;

  led_pwm_driver_if cfg_if ();

  led_pwm_driver #(.PRESCALE(1), .PCNT_W(16)) u_dut0 (
    .led_clk(led_clk), .ledrst(ledrst), .cfg(cfg_if.slave), .ledin(ledin),
    .ledpin(ledpin0), .blink_phase(blink0), .pwm_wrap(wrap0)
  );

  led_pwm_driver #(.PRESCALE(3), .PCNT_W(16)) u_dut1 (
    .led_clk(led_clk), .ledrst(ledrst), .cfg(cfg_if.slave), .ledin(ledin),
    .ledpin(ledpin1), .blink_phase(blink1), .pwm_wrap(wrap1)
  );

  always #5 led_clk = ~led_clk;

  // Reference state: edges since reset, config, and wraps counted since the last period write.
  int m_t;
  int m_duty;
  int m_period;
  int m_mask;
  int m_wraps[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int ps(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int eff(input int d);
`ifdef LED_GAMMA_EN
    return (d * d) / 256;
`else
    return d;
`endif
  endfunction

  function automatic bit pwm_on_of(input int t, input int p, input int d);
    return (d == 255) || (((t / p) % 256) < eff(d));
  endfunction

  function automatic bit wrap_of(input int t, input int p);
    return ((t % p) == p - 1) && (((t / p) % 256) == 255);
  endfunction

  function automatic bit phase_of(input int wraps, input int per);
    if (per == 0) return 1'b1;
    return ((wraps / per) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_t = 0; m_duty = 255; m_period = 0; m_mask = 0;
    m_wraps[0] = 0; m_wraps[1] = 0;
  endtask

  // One clock cycle: drive, predict, clock, check. Entered and left just after a falling edge.
  task automatic step(input bit cs, input bit wr, input logic [1:0] a,
                      input logic [15:0] wd, input logic [23:0] din);
    logic [23:0] exp_pin[2];
    bit          exp_wrap[2];
    bit          on, ph, per_wr;
    cfg_if.cfgcs = cs; cfg_if.cfgwrite = wr; cfg_if.cfgaddr = a; cfg_if.cfgwdata = wd;
    ledin = din;
    for (int i = 0; i < 2; i++) begin
      on = pwm_on_of(m_t, ps(i), m_duty);
      ph = phase_of(m_wraps[i], m_period);
      for (int g = 0; g < 3; g++)
        exp_pin[i][8*g +: 8] = din[8*g +: 8] & {8{on & (ph | !m_mask[g])}};
      exp_wrap[i] = wrap_of(m_t, ps(i));
    end
    per_wr = cs && wr && (a == 2'b01);
    for (int i = 0; i < 2; i++)
      if (!per_wr && m_period != 0 && exp_wrap[i]) m_wraps[i]++;
    if (cs && wr) begin
      case (a)
        2'b00: m_duty = int'(wd[7:0]);
        2'b01: begin m_period = int'(wd); m_wraps[0] = 0; m_wraps[1] = 0; end
        2'b10: m_mask = int'(wd[2:0]);
        default: ;
      endcase
    end
    m_t++;
    @(posedge led_clk); #1;
    chk("ledpin0", 32'(ledpin0), 32'(exp_pin[0]));
    chk("ledpin1", 32'(ledpin1), 32'(exp_pin[1]));
    chk("phase0", 32'(blink0), 32'(phase_of(m_wraps[0], m_period)));
    chk("phase1", 32'(blink1), 32'(phase_of(m_wraps[1], m_period)));
    chk("wrap0", 32'(wrap0), 32'(exp_wrap[0]));
    chk("wrap1", 32'(wrap1), 32'(exp_wrap[1]));
    @(negedge led_clk);
  endtask

  task automatic idle(input logic [23:0] din);
    step(1'b0, 1'b0, 2'b00, 16'h0000, din);
  endtask

  task automatic wr_cfg(input logic [1:0] a, input logic [15:0] wd, input logic [23:0] din);
    step(1'b1, 1'b1, a, wd, din);
  endtask

  initial begin
    int on_cnt, wr_cnt, tog, low_bad, r;
    bit prev, found;
    logic [15:0] wd;
    logic [23:0] cur_in;

    ledrst = 1'b1;
    cfg_if.cfgcs = 1'b0; cfg_if.cfgwrite = 1'b0; cfg_if.cfgaddr = 2'b00; cfg_if.cfgwdata = 16'h0;
    ledin = 24'h000000;
    model_reset();
    repeat (3) @(posedge led_clk);
    @(negedge led_clk);
    chk("rst_pin0", 32'(ledpin0), 32'h0);
    chk("rst_phase0", 32'(blink0), 32'h1);
    chk("rst_wrap0", 32'(wrap0), 32'h0);
    ledrst = 1'b0;

    // Default config: LEDs follow ledin, no blinking.
    repeat (20) idle(24'hA5A5A5);
    chk("dflt_pin", 32'(ledpin0), 32'h00A5A5A5);
    chk("dflt_phase", 32'(blink0), 32'h1);

    // Random configuration traffic.
    cur_in = 24'(($urandom));
    for (int n = 0; n < 12000; n++) begin
      if ($urandom_range(0, 4) == 0) cur_in = 24'($urandom);
      r = $urandom_range(0, 399);
      if (r == 0) begin
        case ($urandom_range(0, 2))
          0: begin
            case ($urandom_range(0, 3))
              0: wd = 16'h0000;
              1: wd = 16'h00FF;
              2: wd = 16'h0040;
              default: wd = 16'($urandom);
            endcase
            wr_cfg(2'b00, wd, cur_in);
          end
          1: wr_cfg(2'b01, 16'($urandom_range(0, 3)), cur_in);
          default: wr_cfg(2'b10, 16'($urandom), cur_in);
        endcase
      end else if (r == 1) begin
        step(1'b0, 1'b1, 2'($urandom), 16'($urandom), cur_in);
      end else if (r == 2) begin
        wr_cfg(2'b11, 16'($urandom), cur_in);
      end else begin
        idle(cur_in);
      end
    end

    // Duty 64 and 128: count lit cycles over one full PWM period of the PRESCALE=1 instance.
    wr_cfg(2'b01, 16'h0000, 24'hFFFFFF);
    wr_cfg(2'b10, 16'h0000, 24'hFFFFFF);
    for (int k = 0; k < 2; k++) begin
      wr_cfg(2'b00, (k == 0) ? 16'd64 : 16'd128, 24'hFFFFFF);
      idle(24'hFFFFFF);
      on_cnt = 0; wr_cnt = 0;
      for (int n = 0; n < 256; n++) begin
        idle(24'hFFFFFF);
        if (ledpin0 == 24'hFFFFFF) on_cnt++;
        if (wrap0) wr_cnt++;
      end
      chk((k == 0) ? "on_cnt_d64" : "on_cnt_d128", 32'(on_cnt), 32'(eff((k == 0) ? 64 : 128)));
      chk("wrap_per_256", 32'(wr_cnt), 32'd1);
    end

    // Blink: group 2 toggles every 512 cycles, lower groups stay lit.
    wr_cfg(2'b00, 16'h00FF, 24'hFFFFFF);
    wr_cfg(2'b10, 16'h0004, 24'hFFFFFF);
    wr_cfg(2'b01, 16'h0002, 24'hFFFFFF);
    prev = blink0; tog = 0; low_bad = 0;
    for (int n = 0; n < 2048; n++) begin
      idle(24'hFFFFFF);
      if (blink0 != prev) tog++;
      prev = blink0;
      if (ledpin0[15:0] != 16'hFFFF) low_bad++;
    end
    chk("blink_toggles", 32'(tog), 32'd4);
    chk("low_groups_lit", 32'(low_bad), 32'd0);

    // Ignored writes: address 11 and a write without chip select.
    step(1'b1, 1'b1, 2'b11, 16'hFFFF, 24'hFFFFFF);
    step(1'b0, 1'b1, 2'b00, 16'h0010, 24'hFFFFFF);
    step(1'b0, 1'b1, 2'b01, 16'h0000, 24'hFFFFFF);
    repeat (20) idle(24'hFFFFFF);

    // Asynchronous reset in the dark blink half with a dim duty.
    wr_cfg(2'b00, 16'd10, 24'hFFFFFF);
    wr_cfg(2'b01, 16'h0001, 24'hFFFFFF);
    found = 1'b0;
    for (int n = 0; n < 600 && !found; n++) begin
      idle(24'hFFFFFF);
      if (blink0 == 1'b0) found = 1'b1;
    end
    chk("reach_phase0", 32'(blink0), 32'h0);
    #2 ledrst = 1'b1;
    #1;
    chk("arst_pin0", 32'(ledpin0), 32'h0);
    chk("arst_pin1", 32'(ledpin1), 32'h0);
    chk("arst_phase0", 32'(blink0), 32'h1);
    chk("arst_phase1", 32'(blink1), 32'h1);
    chk("arst_wrap0", 32'(wrap0), 32'h0);
    @(negedge led_clk);
    ledrst = 1'b0;
    model_reset();
    for (int n = 0; n < 40; n++) idle(24'($urandom));
    idle(24'h5A3C96);
    chk("post_rst_pin", 32'(ledpin0), 32'h005A3C96);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Downstream stage of the LED register block: takes the 24-bit latched LED word and drives the physical board LED pins.
- Adds global brightness control by PWM and per-byte-group blinking.
- Configured through a small memory-mapped write port decoded by memorio, using the same cs/write/addr convention as the LED register block.

Parameters:
- PRESCALE, 16, led_clk cycles per PWM step (>=1); full PWM period = 256*PRESCALE cycles.
- PCNT_W, 16, width of the prescaler counter; must hold PRESCALE-1.

Ports:
- led_clk  in  1  clock
- ledrst  in  1  reset, asynchronous, active-high
- cfgcs  in  1  chip select from memorio
- cfgwrite  in  1  write strobe
- cfgaddr  in  2  register select
- cfgwdata  in  16  write data
- ledin  in  24  LED word from the LED register block
- ledpin  out  24  board LED pins, registered
- blink_phase  out  1  current blink phase (1 = lit half)
- pwm_wrap  out  1  one-cycle pulse at the end of each PWM period

Behaviour:
- Reset (async, any cycle, mid-operation included):
  - duty=8'hFF, period=16'h0000, mask=3'b000
  - prescaler, pwm_cnt and blink_cnt=0
  - blink_phase=1, ledpin=24'h000000, pwm_wrap=0
- Config write happens when cfgcs && cfgwrite at a rising edge:
  - addr 00: duty <= cfgwdata[7:0]
  - addr 01: period <= cfgwdata[15:0]; blink_cnt<=0 and blink_phase<=1 on the same edge
  - addr 10: mask <= cfgwdata[2:0]; bit g selects group ledpin[8g+7:8g]
  - addr 11: ignored, no state change
  - Written values take effect from the next edge.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is asserted internally during the cycle the count equals PRESCALE-1.
  - PRESCALE=1 gives a tick every cycle.
- PWM counter:
  - pwm_cnt (8 bits) increments on tick and wraps 255->0.
  - wrap event = tick && pwm_cnt==255.
  - pwm_wrap is a registered copy of the wrap event (1-cycle pulse).
- PWM output:
  - pwm_on = (duty==8'hFF) || (pwm_cnt < effective_duty).
  - duty 0: always off. duty 255: always on, no gap.
- Blink:
  - period==0: blinking disabled; blink_phase held at 1 and blink_cnt held at 0.
  - Otherwise, on each wrap event blink_cnt increments.
  - When blink_cnt==period-1 at a wrap: blink_cnt<=0 and blink_phase toggles.
  - Half-cycle length = period PWM periods.
  - A period write on the same edge as a wrap: the write wins (blink_cnt=0, phase=1).
- Output:
  - ledpin[i] <= ledin[i] & pwm_on & (blink_phase | ~mask[i/8]), registered.
  - Latency 1 cycle from ledin or from PWM/blink state to ledpin.
- No backpressure and no read path; cfgwrite without cfgcs is ignored.

Optional Feature:
- Macro LED_GAMMA_EN.
- Defined: effective_duty = (duty*duty)>>8, computed in 16 bits and taking the upper 8 bits; duty 8'hFF still forces always-on. Examples: duty 16 -> 1, duty 128 -> 64.
- Undefined: effective_duty = duty (linear).

Test Plan:
- Reset then ledin=24'hA5A5A5 with default config -> ledpin=24'hA5A5A5 one cycle later and stays constant; blink_phase=1.
- PRESCALE=1, duty=8'd64, ledin=24'hFFFFFF -> over 256 cycles ledpin=all-ones for exactly 64 cycles (pwm_cnt 0..63), zero for 192; pwm_wrap pulses once every 256 cycles.
- PRESCALE=1, duty=8'hFF, period=2, mask=3'b100, ledin=24'hFFFFFF -> ledpin[23:16] alternates on/off every 512 cycles; ledpin[15:0] stays 16'hFFFF; blink_phase toggles every 512 cycles.
- Write cfgaddr=11 with data 16'hFFFF, and write addr 00 with cfgcs=0 -> duty, period and mask unchanged, ledpin unaffected.
- Assert ledrst asynchronously mid-blink with phase=0 and duty=8'd10 -> ledpin=0 immediately, blink_phase=1; after release, duty=8'hFF so ledpin equals ledin with 1-cycle latency.
- LED_GAMMA_EN defined, PRESCALE=1, duty=8'd128 -> ledpin on for 64 of every 256 cycles; without the macro -> on for 128 of every 256 cycles.
